// File: rtl/bkeppner_pkg.sv
// Shared definitions for the bkeppner_uart_rx slice.
//   uart_rx_state_t       : receiver FSM state encoding
//   UART_DATA_BITS        : data bits per frame
//   UART_MIN_CLKS_PER_BIT : smallest usable oversampling ratio
//   uart_half_bit()       : counter preload for the mid-start-bit sample
package bkeppner_pkg;

  localparam int unsigned UART_DATA_BITS        = 8;
  localparam int unsigned UART_MIN_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    UartIdle   = 3'd0,
    UartStart  = 3'd1,
    UartData   = 3'd2,
    UartParity = 3'd3,
    UartStop   = 3'd4
  } uart_rx_state_t;

  // Floor division keeps the start sample at t0 + N/2.
  function automatic logic [15:0] uart_half_bit(input int unsigned clks_per_bit);
    return 16'(clks_per_bit / 2 - 1);
  endfunction

endpackage

// File: rtl/bkeppner_sync.sv
// N-stage bit synchroniser, reset to 1 so an idle-high line does not look
// like activity coming out of reset.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input
//   q     out synchronised output
module bkeppner_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/bkeppner_uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Received bytes are offered on a valid/ready handshake; framing, parity and
// overrun events are single-cycle pulses.
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   ena        in  design enable; low forces IDLE and suppresses events
//   rx         in  raw serial line, idle high
//   rx_data    out received byte, stable while rx_valid
//   rx_valid   out byte available
//   rx_ready   in  consumer accepts the byte
//   frame_err  out pulse: stop bit sampled low
//   parity_err out pulse: even-parity mismatch (constant 0 without parity)
//   overrun    out pulse: good frame dropped because rx_valid was still high
//   busy       out FSM not idle
module bkeppner_uart_rx
  import bkeppner_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] HalfBit = uart_half_bit(CLKS_PER_BIT);
  localparam logic [15:0] FullBit = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LastBit = 3'(UART_DATA_BITS - 1);

  logic rxs;

  bkeppner_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rxs)
  );

  uart_rx_state_t state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
  logic           par_bad;
`ifdef UART_RX_PARITY_EN
  logic           par_q, par_d;
  logic           perr_q, perr_d;

  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  logic expire;
  assign expire = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    if (!ena) begin
      state_d = UartIdle;
    end else begin
      unique case (state_q)
        UartIdle: begin
          if (!rxs) begin
            state_d = UartStart;
            cnt_d   = HalfBit;
          end
        end
        UartStart: begin
          if (!expire) begin
            cnt_d = cnt_q - 16'd1;
          end else if (rxs) begin
            state_d = UartIdle;
          end else begin
            state_d = UartData;
            idx_d   = 3'd0;
            cnt_d   = FullBit;
          end
        end
        UartData: begin
          if (!expire) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            shift_d = {rxs, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            cnt_d   = FullBit;
            if (idx_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
              state_d = UartParity;
`else
              state_d = UartStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        UartParity: begin
          if (!expire) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            par_d   = rxs;
            cnt_d   = FullBit;
            state_d = UartStop;
          end
        end
`endif
        UartStop: begin
          if (!expire) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            // Return to IDLE on the sample itself to regain half a bit of margin.
            state_d = UartIdle;
            if (!rxs) begin
              ferr_d = 1'b1;
            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              perr_d = 1'b1;
`endif
            end else if (valid_q) begin
              ovr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = UartIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UartIdle;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != UartIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/bkeppner_uart_rx.md
# bkeppner_uart_rx

UART receive front end for `tt_um_bkeppner`. It takes the asynchronous serial line from a dedicated input pin and deserialises 8N1 frames into bytes, 8E1 when parity is compiled in. Bytes go to the project core over a valid/ready handshake. Framing, parity and overrun events are reported as single-cycle pulses.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per bit (10 MHz / 115200). Legal range 4..65535.
- `SYNC_STAGES`, default 2: flops in the input synchroniser. Legal range 2..3.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset. Clears all state.
- `ena`  in  1  design-select enable. While low, the FSM is forced to IDLE and no events are produced.
- `rx`  in  1  raw serial line, idle high. Typically `ui_in[3]`.
- `rx_data`  out  8  received byte. Stable while `rx_valid` is high.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts the byte. Transfer occurs when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 when parity is disabled.
- `overrun`  out  1  one-cycle pulse: a good frame completed while `rx_valid` was still high. The new byte is dropped.
- `busy`  out  1  FSM not in IDLE.

## Operation
- The input passes through a `SYNC_STAGES`-flop synchroniser, reset to 1. The FSM sees only `rxs`, the synchroniser output.
- FSM states are IDLE, START, DATA, PARITY (only present when compiled in) and STOP.
- IDLE: if `rxs` is 0, go to START and load the bit counter with `CLKS_PER_BIT/2 - 1`, using floor division.
- START: when the counter expires, sample `rxs`.
  - If it is 1, treat it as a false start: go to IDLE with no event.
  - If it is 0, go to DATA with bit index 0 and counter `CLKS_PER_BIT - 1`.
- DATA: when the counter expires, shift `rxs` into the shift register LSB-first. After bit 7, go to PARITY if compiled in, otherwise STOP.
- PARITY: sample one bit. Even parity is required: the XOR of the 8 data bits and the parity bit must be 0.
- STOP: sample one bit, then go to IDLE in the same cycle as the sample. This gives the half-bit resync margin that back-to-back frames need.
- On the stop sample there are four outcomes:
  - Stop = 0: pulse `frame_err`. `rx_data` and `rx_valid` are unchanged.
  - Parity mismatch with stop = 1: pulse `parity_err`. No byte is delivered.
  - Good frame with `rx_valid` = 0: load `rx_data` and set `rx_valid`.
  - Good frame with `rx_valid` = 1: pulse `overrun` and keep the old byte. This applies even if `rx_ready` is high in that cycle, so accept and overrun never coincide.
- Handshake:
  - `rx_valid` stays high until the cycle after `rx_valid && rx_ready`.
  - `rx_data` does not change while `rx_valid` is high.
- A line held low: after a `frame_err`, IDLE immediately sees 0 and starts a new frame. This repeats every frame length while the break persists; each repeat ends in `frame_err`.
- `ena` falling mid-frame aborts the frame: the FSM goes to IDLE with no event. `rx_valid` and `rx_data` are kept.
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0, synchroniser=1.

## Timing
- Let t0 be the first cycle in which IDLE sees `rxs`=0, and N = `CLKS_PER_BIT`.
- Start sample: t0 + N/2.
- Data bit k sample (k = 0..7): t0 + N/2 + (k+1)·N.
- Parity sample, if enabled: t0 + N/2 + 9N.
- Stop sample: t0 + N/2 + 9N, or + 10N with parity.
- `rx_valid` and the event pulses register in the cycle after the stop sample.
- Pin-to-t0 latency is `SYNC_STAGES` cycles.
- Sustained throughput is one byte per frame time, provided the consumer accepts within one frame.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, frames are 8E1 (11 bits), and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: frames are 8N1 (10 bits), there is no PARITY state, and `parity_err` is a constant 0.
- The port list is identical in both builds.

## Structure
Shared package `bkeppner_pkg` holds:
- the `uart_rx_state_t` enum;
- `UART_DATA_BITS` = 8;
- the `UART_MIN_CLKS_PER_BIT` = 4 constant.

Sub-module `bkeppner_sync`: an N-stage reset-to-1 bit synchroniser, reused for other `ui_in` pins.

`bkeppner_uart_rx` holds the FSM, the bit counter, the shift register and the output register.

## Test plan
Run with `CLKS_PER_BIT`=8 unless noted.
- Reset mid-frame: assert `rst_n` low during DATA → all outputs 0 and `busy`=0 within 0 cycles (asynchronous). The next clean frame is received correctly.
- Single byte: send 0xA5 with `rx_ready` held 0 → `rx_valid`=1 and `rx_data`=0xA5 at the predicted cycle. Raise `rx_ready` for one cycle → `rx_valid`=0 on the next cycle.
- Glitch rejection: a 2-cycle low pulse on `rx` → `busy` rises, then falls at the start sample. No event and `rx_valid` stays 0.
- Framing error: send 0x3C with stop = 0 → one-cycle `frame_err`. `rx_valid` stays 0 and `rx_data` keeps its previous value.
- Overrun: send back-to-back 0x11 and 0x22 with `rx_ready`=0 → `rx_data`=0x11 held and one `overrun` pulse at the end of the second frame. Accept, then send 0x33 → `rx_data`=0x33.
- Parity (`UART_RX_PARITY_EN`): 0x07 with parity bit 1 → delivered. 0x07 with parity bit 0 → `parity_err` pulse and no `rx_valid`.
